// File: rtl/clk_div_bank_if.sv
// Configuration / status bundle for clk_div_bank.
// The optional per-channel enable (ch_en) exists only when
// CLK_DIV_BANK_GATE_EN is defined.
// Handshake: cfg_wr is a single-cycle strobe with no ready; the block always
// samples cfg_ch/cfg_div/cfg_phase on the rising edge where cfg_wr is high.
interface clk_div_bank_if #(
   parameter int NUM_CH = 3,
   parameter int DIV_W  = 16
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic              cfg_wr;
   logic [CH_W-1:0]   cfg_ch;
   logic [DIV_W-1:0]  cfg_div;
   logic [DIV_W-1:0]  cfg_phase;
   logic [NUM_CH-1:0] outclk;
   logic [NUM_CH-1:0] tick;
   logic              locked;
   logic              cfg_busy;
   logic [1:0]        state;
`ifdef CLK_DIV_BANK_GATE_EN
   logic [NUM_CH-1:0] ch_en;

   modport master (
      output cfg_wr, cfg_ch, cfg_div, cfg_phase, ch_en,
      input  outclk, tick, locked, cfg_busy, state
   );
   modport slave (
      input  cfg_wr, cfg_ch, cfg_div, cfg_phase, ch_en,
      output outclk, tick, locked, cfg_busy, state
   );
`else
   modport master (
      output cfg_wr, cfg_ch, cfg_div, cfg_phase,
      input  outclk, tick, locked, cfg_busy, state
   );
   modport slave (
      input  cfg_wr, cfg_ch, cfg_div, cfg_phase,
      output outclk, tick, locked, cfg_busy, state
   );
`endif
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NUM_CH programmable integer clock dividers sharing a
// single alignment/lock FSM. Any accepted configuration write realigns every
// channel to its phase offset, then the bank settles for LOCK_CYCLES cycles
// before reporting locked.
// Optional macro CLK_DIV_BANK_GATE_EN adds a per-channel run enable (ch_en).
// Debug: bus.state exposes the FSM state (0=ALIGN, 1=SETTLE, 2=LOCKED).
module clk_div_bank #(
   parameter int NUM_CH      = 3,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 5,
   parameter int LOCK_CYCLES = 16
) (
   input  logic           refclk,
   input  logic           rst,
   clk_div_bank_if.slave  bus
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [1:0] ST_ALIGN  = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
   localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
   localparam logic [15:0]      SETTLE_LAST = 16'(LOCK_CYCLES - 1);
   localparam logic [CH_W:0]    NUM_CH_V    = (CH_W + 1)'(NUM_CH);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [15:0]       r_settle;
   logic [DIV_W-1:0]  r_div   [NUM_CH];
   logic [DIV_W-1:0]  r_phase [NUM_CH];
   logic [DIV_W-1:0]  r_cnt   [NUM_CH];
   logic [DIV_W-1:0]  w_cnt_nxt [NUM_CH];
   logic [NUM_CH-1:0] r_outclk;
   logic [NUM_CH-1:0] r_tick;
   logic [NUM_CH-1:0] w_run;
   logic [NUM_CH-1:0] w_live;
   logic [NUM_CH-1:0] w_en;
   logic [NUM_CH-1:0] w_en_prev;
   logic              w_wr_ok;
   logic [DIV_W-1:0]  w_div_eff;
   logic [DIV_W-1:0]  w_phase_eff;

`ifdef CLK_DIV_BANK_GATE_EN
   logic [NUM_CH-1:0] r_en_q;

   // Remember last cycle's enables so a freshly enabled channel reloads its phase.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) r_en_q <= '0;
      else     r_en_q <= bus.ch_en;
   end

   assign w_en      = bus.ch_en;
   assign w_en_prev = r_en_q;
`else
   assign w_en      = '1;
   assign w_en_prev = '1;
`endif

   // Writes to channels beyond the bank are dropped without any side effect.
   assign w_wr_ok = bus.cfg_wr && ({1'b0, bus.cfg_ch} < NUM_CH_V);

   // Sanitise the written ratio/phase so every channel has a real period.
   always_comb begin
      w_div_eff   = (bus.cfg_div < TWO) ? TWO : bus.cfg_div;
      w_phase_eff = (bus.cfg_phase >= w_div_eff) ? (w_div_eff - ONE) : bus.cfg_phase;
   end

   // Next-state logic: a write anywhere forces (or holds) ALIGN.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_ALIGN:  w_state_nxt = w_wr_ok ? ST_ALIGN : ST_SETTLE;
         ST_SETTLE: begin
            if (w_wr_ok)                    w_state_nxt = ST_ALIGN;
            else if (r_settle == SETTLE_LAST) w_state_nxt = ST_LOCKED;
         end
         ST_LOCKED: if (w_wr_ok) w_state_nxt = ST_ALIGN;
         default:   w_state_nxt = ST_ALIGN;
      endcase
   end

   // FSM state register.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) r_state <= ST_ALIGN;
      else     r_state <= w_state_nxt;
   end

   // Settle counter: counts SETTLE cycles, cleared whenever SETTLE is left or not entered.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst)
         r_settle <= '0;
      else if (r_state == ST_SETTLE && w_state_nxt == ST_SETTLE)
         r_settle <= r_settle + 16'd1;
      else
         r_settle <= '0;
   end

   // Per-channel ratio/phase registers, loaded by accepted writes.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_div[c]   <= DEF_DIV;
            r_phase[c] <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr_ok && ({1'b0, bus.cfg_ch} == (CH_W + 1)'(c))) begin
               r_div[c]   <= w_div_eff;
               r_phase[c] <= w_phase_eff;
            end
         end
      end
   end

   // Next count: run-and-wrap while counting, otherwise park at the phase offset.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         w_run[c]  = (r_state != ST_ALIGN) && w_en[c] && w_en_prev[c];
         w_live[c] = (w_state_nxt != ST_ALIGN) && w_en[c];
         if (w_run[c])
            w_cnt_nxt[c] = (r_cnt[c] >= (r_div[c] - ONE)) ? '0 : (r_cnt[c] + ONE);
         else
            w_cnt_nxt[c] = r_phase[c];
      end
   end

   // Counters plus outputs registered from the next count, so they line up with cnt.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) r_cnt[c] <= '0;
         r_outclk <= '0;
         r_tick   <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_cnt[c]    <= w_cnt_nxt[c];
            r_outclk[c] <= w_live[c] && (w_cnt_nxt[c] < (r_div[c] >> 1));
            r_tick[c]   <= w_live[c] && (w_cnt_nxt[c] == '0);
         end
      end
   end

   assign bus.outclk   = r_outclk;
   assign bus.tick     = r_tick;
   assign bus.locked   = (r_state == ST_LOCKED);
   assign bus.cfg_busy = (r_state != ST_LOCKED);
   assign bus.state    = r_state;

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank with default parameters. A reference model steps
// once per rising edge and queues the expected output vector for the coming
// cycle; an independent monitor pops and compares on every falling edge.
module tb_clk_div_bank;
   localparam int NC   = 3;
   localparam int DW   = 16;
   localparam int DEFD = 5;
   localparam int LOCK = 16;
   localparam int CH_W = 2;
   localparam int W    = 2 + 2 * NC;
   localparam logic [W-1:0] RESET_VEC = W'(1) << (2 * NC);

   logic refclk = 1'b0;
   logic rst    = 1'b1;

   clk_div_bank_if #(.NUM_CH(NC), .DIV_W(DW)) bus ();

   clk_div_bank #(
      .NUM_CH(NC), .DIV_W(DW), .DEFAULT_DIV(DEFD), .LOCK_CYCLES(LOCK)
   ) dut (
      .refclk(refclk),
      .rst   (rst),
      .bus   (bus.slave)
   );

   // Clock and watchdog.
   always #5 refclk = ~refclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad   = 0;
   logic [W-1:0] exp_q[$];
   bit started = 0;

   // Reference model: time since alignment, closed-form counter per channel.
   int m_div   [NC];
   int m_phase [NC];
   bit m_align;
   int m_t;

   function automatic logic [W-1:0] model_vec();
      logic [NC-1:0] oc, tk;
      logic lk;
      int cnt;
      if (m_align) return RESET_VEC;
      for (int c = 0; c < NC; c++) begin
         cnt   = (m_phase[c] + m_t) % m_div[c];
         tk[c] = (cnt == 0);
         oc[c] = (cnt < m_div[c] / 2);
      end
      lk = (m_t >= LOCK);
      return {lk, ~lk, tk, oc};
   endfunction

   initial begin
      int d, p;
      bit acc;
      forever begin
         @(posedge refclk);
         if (rst) begin
            for (int c = 0; c < NC; c++) begin
               m_div[c]   = DEFD;
               m_phase[c] = 0;
            end
            m_align = 1;
            m_t     = 0;
         end else begin
            acc = bus.cfg_wr && (int'(bus.cfg_ch) < NC);
            if (acc) begin
               d = (bus.cfg_div < 2) ? 2 : int'(bus.cfg_div);
               p = (int'(bus.cfg_phase) >= d) ? d - 1 : int'(bus.cfg_phase);
               m_div[bus.cfg_ch]   = d;
               m_phase[bus.cfg_ch] = p;
            end
            if (acc) m_align = 1;
            else if (m_align) begin
               m_align = 0;
               m_t     = 0;
            end else m_t++;
         end
         exp_q.push_back(model_vec());
         started = 1;
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%b want=%b (locked,busy,tick,outclk)", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, act, exp);
      end
   endtask

   // Monitor: one comparison per cycle against the queued expectation.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge refclk);
         if (started) begin
            if (exp_q.size() == 0) begin
               check_int("queue_empty", 0, 1);
            end else begin
               e = exp_q.pop_front();
               if (rst) e = RESET_VEC;
               check("cycle", {bus.locked, bus.cfg_busy, bus.tick, bus.outclk}, e);
            end
         end
      end
   end

   // Driver tasks: all called and returning at posedge + 1.
   task automatic cycle();
      @(posedge refclk);
      #1;
   endtask

   task automatic write(input logic [CH_W-1:0] ch, input logic [DW-1:0] d, input logic [DW-1:0] p);
      bus.cfg_wr    = 1'b1;
      bus.cfg_ch    = ch;
      bus.cfg_div   = d;
      bus.cfg_phase = p;
      cycle();
      bus.cfg_wr    = 1'b0;
      bus.cfg_ch    = CH_W'($urandom_range(0, 3));
      bus.cfg_div   = DW'($urandom_range(0, 20));
      bus.cfg_phase = DW'($urandom_range(0, 20));
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      check("async_rst", {bus.locked, bus.cfg_busy, bus.tick, bus.outclk}, RESET_VEC);
      repeat ($urandom_range(1, 3)) cycle();
      rst = 1'b0;
   endtask

   task automatic cycles_to_lock(input string name, input int exp);
      int n = 0;
      do begin
         @(negedge refclk);
         n++;
      end while (!bus.locked && n < 100);
      check_int(name, n, exp);
      @(posedge refclk);
      #1;
   endtask

   // Stimulus.
   initial begin
      int r, gap;
      bus.cfg_wr    = 1'b0;
      bus.cfg_ch    = '0;
      bus.cfg_div   = '0;
      bus.cfg_phase = '0;
`ifdef CLK_DIV_BANK_GATE_EN
      bus.ch_en     = '1;
`endif
      repeat (3) cycle();
      rst = 1'b0;
      cycles_to_lock("lock_after_reset", 18);
      repeat (12) cycle();

      write(2'd1, 16'd4, 16'd1);          // divide-by-4, phase 1
      repeat (25) cycle();
      write(2'd2, 16'd0, 16'd9);          // sanitised to div 2, phase 1
      repeat (25) cycle();
      write(2'd0, 16'd6, 16'd2);          // three back-to-back writes
      write(2'd1, 16'd3, 16'd0);
      write(2'd2, 16'd5, 16'd4);
      repeat (25) cycle();
      write(2'd3, 16'd7, 16'd1);          // out-of-range channel
      repeat (5) cycle();
      write(2'd0, 16'd7, 16'd3);          // then reset mid-settle
      repeat (6) cycle();
      pulse_reset();
      repeat (25) cycle();
      write(2'd0, 16'd1, 16'd0);          // div 1 -> 2
      repeat (8) cycle();
      write(2'd1, 16'd9, 16'd9);          // phase == div -> div-1
      repeat (22) cycle();

      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 19);
         if (r == 0) pulse_reset();
         else write(CH_W'($urandom_range(0, 3)), DW'($urandom_range(0, 12)),
                    DW'($urandom_range(0, 14)));
         gap = (r < 4) ? 0 : $urandom_range(1, 30);
         repeat (gap) cycle();
      end

      repeat (3) cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NUM_CH, default 3: number of output clock channels, legal range 1..8.
REQ-002 Parameter DIV_W, default 16: width of the divide-ratio and phase fields.
REQ-003 Parameter DEFAULT_DIV, default 5: divide ratio loaded into every channel at reset.
REQ-004 Parameter LOCK_CYCLES, default 16: settle cycles between realignment and locked assertion, legal range 1..65535.
REQ-005 refclk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 cfg_wr  in  1  one-cycle configuration write strobe.
REQ-008 cfg_ch  in  max(1,clog2(NUM_CH))  target channel of the write.
REQ-009 cfg_div  in  DIV_W  divide ratio N for the target channel.
REQ-010 cfg_phase  in  DIV_W  phase offset, in refclk cycles, for the target channel.
REQ-011 outclk  out  NUM_CH  divided clock per channel, registered.
REQ-012 tick  out  NUM_CH  one-cycle pulse per channel at each period start, registered.
REQ-013 locked  out  1  all channels aligned and settled.
REQ-014 cfg_busy  out  1  high whenever locked is low.

Function
REQ-015 Each channel holds div[c] and phase[c] registers and a counter cnt[c] of DIV_W bits.
REQ-016 A written cfg_div of 0 or 1 is stored as 2.
REQ-017 A cfg_phase greater than or equal to the effective divide ratio is stored as divide ratio minus 1.
REQ-018 A cfg_wr with cfg_ch >= NUM_CH is ignored entirely, with no state change.
REQ-019 Control FSM states: ALIGN, SETTLE, LOCKED.
REQ-020 ALIGN lasts exactly one cycle; every cnt[c] loads phase[c]; outclk and tick are forced to 0.
REQ-021 ALIGN to SETTLE is unconditional, unless cfg_wr is accepted in the same cycle, in which case the FSM remains in ALIGN.
REQ-022 SETTLE: counters run; the settle counter counts LOCK_CYCLES cycles, then the FSM moves to LOCKED.
REQ-023 An accepted cfg_wr in SETTLE or LOCKED updates the registers and moves the FSM to ALIGN on the next edge.
REQ-024 On that transition all channels realign simultaneously; locked falls in the first cycle after the write.
REQ-025 Counting in SETTLE/LOCKED: cnt[c] increments each cycle and wraps from div[c]-1 to 0.
REQ-026 outclk[c] = 1 in exactly those cycles where cnt[c] < floor(div[c]/2); the output lags the counter by 0 cycles (registered from the next-count value).
REQ-027 tick[c] = 1 in exactly the cycles where cnt[c] == 0 and the FSM is in SETTLE or LOCKED.
REQ-028 locked = 1 only in the LOCKED state.

Reset
REQ-029 While rst is high, asynchronously:
  - FSM to ALIGN
  - div[c] = DEFAULT_DIV, phase[c] = 0, cnt[c] = 0
  - settle counter = 0
  - outclk = 0, tick = 0, locked = 0, cfg_busy = 1
REQ-030 The first cycle after rst deasserts is an ALIGN cycle.
REQ-031 rst asserted mid-settle or mid-period discards all runtime configuration.

Configuration
REQ-032 Macro CLK_DIV_BANK_GATE_EN: when defined, adds input ch_en, width NUM_CH.
  - While ch_en[c] = 0: cnt[c] is held at phase[c]; outclk[c] = 0 and tick[c] = 0.
  - A 0-to-1 transition restarts channel c from phase[c] without affecting locked or any other channel.
REQ-033 When CLK_DIV_BANK_GATE_EN is not defined, the ch_en port does not exist and all channels always run.

Verification
REQ-034 Reset then release with defaults (NUM_CH=3, DIV=5, LOCK_CYCLES=16) -> locked rises on the 18th cycle after release; each outclk reads 1,1,0,0,0 repeating; tick fires every 5 cycles, all channels in phase.
REQ-035 In LOCKED, write ch1 div=4 phase=1 -> locked low for 17 cycles after the write; ch1 then reads cnt 1,2,3,0, outclk 1,0,0,1, tick coincident with cnt=0.
REQ-036 Write cfg_div=0 and cfg_phase=9 to ch2 -> ch2 runs divide-by-2 with phase 1, outclk toggling each cycle starting at 0.
REQ-037 Back-to-back cfg_wr in 3 consecutive cycles -> FSM stays in ALIGN for all three cycles; locked rises 17 cycles after the last write.
REQ-038 cfg_wr with cfg_ch=3 while NUM_CH=3 -> no change; locked stays 1.
REQ-039 rst pulsed during SETTLE after a div=7 write -> outputs clear immediately; div reverts to 5 after release.
